i2c_cfg_sequencer: RTL



---
 rtl/i2c_seq_pkg.sv | 36 +++
 rtl/i2c_seq_timer.sv | 24 ++
 rtl/i2c_cfg_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the I2C boot-configuration sequencer.
// Optional feature macro: I2C_SEQ_DELAY_EN (delay entries, dev addr 7'h7F).
package i2c_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_GAP,
    S_FINISH,
    S_ERROR
`ifdef I2C_SEQ_DELAY_EN
    ,S_DELAY
`endif
  } state_t;

  // ROM word layout: [23]=END, [22:16]=dev, [15:8]=reg, [7:0]=data
  localparam int END_BIT = 23;
  localparam int DEV_HI  = 22;
  localparam int DEV_LO  = 16;
  localparam int REG_HI  = 15;
  localparam int REG_LO  = 8;
  localparam int DAT_HI  = 7;
  localparam int DAT_LO  = 0;

  localparam logic [6:0] DELAY_DEV_ADDR = 7'h7F;

  // Timer must hold the 20-bit timeout, or {reg,data}*1024 when delays exist.
`ifdef I2C_SEQ_DELAY_EN
  localparam int TMR_W = 26;
`else
  localparam int TMR_W = 20;
`endif

endpackage

// File: rtl/i2c_seq_timer.sv
// Loadable down-counter shared by the gap, timeout and delay phases.
// Loaded with N-1 on state entry, expire is high in the Nth cycle.
module i2c_seq_timer #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  // Count down to zero and park there until reloaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - W'(1);
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Boot-time table walker: issues each ROM entry as one I2C write, with
// bus-idle gaps, hung-transaction timeout, bounded retry and error report.
// Optional feature macro: I2C_SEQ_DELAY_EN (dev 7'h7F entries become waits).
module i2c_cfg_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int          ROM_AW         = 6,
  parameter logic [15:0] GAP_CYCLES     = 16'd500,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd50000,
  parameter int          MAX_RETRY      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [23:0]       i_rom_data,
  output logic              o_i2c_en,
  output logic [6:0]        o_device_addr,
  output logic [7:0]        o_data_addr,
  output logic [7:0]        o_write_data,
  input  logic              i_done_flag,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ROM_AW-1:0] o_err_idx
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t             state, state_n;
  logic [ROM_AW-1:0]  idx;
  logic [RW-1:0]      retry;
  logic               wrap;      // last increment of idx rolled past the top entry
  logic               last_try;
  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_exp;
  logic               rom_end;

  assign rom_end  = i_rom_data[END_BIT];
  assign last_try = (retry == RW'(MAX_RETRY));

`ifdef I2C_SEQ_DELAY_EN
  logic             is_delay;
  logic [TMR_W-1:0] delay_len;
  assign is_delay  = (i_rom_data[DEV_HI:DEV_LO] == DELAY_DEV_ADDR);
  assign delay_len = {i_rom_data[REG_HI:DAT_LO], 10'd0};
`endif

  i2c_seq_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_exp)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic and timer reload on entry to timed states.
  always_comb begin
    state_n  = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      S_IDLE:  if (i_start) state_n = S_FETCH;
      S_FETCH: state_n = S_LATCH;
      S_LATCH: begin
        if (rom_end) state_n = S_FINISH;
`ifdef I2C_SEQ_DELAY_EN
        else if (is_delay) begin
          state_n  = S_DELAY;
          tmr_load = 1'b1;
          tmr_val  = (delay_len == '0) ? '0 : delay_len - TMR_W'(1);
        end
`endif
        else begin
          state_n  = S_ISSUE;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(TIMEOUT_CYCLES) - TMR_W'(1);
        end
      end
      S_ISSUE: begin
        // done has priority over a simultaneous timeout
        if (i_done_flag || (tmr_exp && !last_try)) begin
          state_n  = S_GAP;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(GAP_CYCLES) - TMR_W'(1);
        end else if (tmr_exp) begin
          state_n = S_ERROR;
        end
      end
      S_GAP:   if (tmr_exp) state_n = wrap ? S_FINISH : S_FETCH;
`ifdef I2C_SEQ_DELAY_EN
      S_DELAY: if (tmr_exp) state_n = (&idx) ? S_FINISH : S_FETCH;
`endif
      S_FINISH: state_n = S_IDLE;
      S_ERROR:  state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Entry index, retry count, error status and registered master outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx           <= '0;
      retry         <= '0;
      wrap          <= 1'b0;
      o_err         <= 1'b0;
      o_err_idx     <= '0;
      o_i2c_en      <= 1'b0;
      o_device_addr <= '0;
      o_data_addr   <= '0;
      o_write_data  <= '0;
    end else begin
      o_i2c_en <= (state_n == S_ISSUE);
      case (state)
        S_IDLE: if (i_start) begin
          idx   <= '0;
          retry <= '0;
          wrap  <= 1'b0;
          o_err <= 1'b0;
        end
        S_LATCH: if (state_n == S_ISSUE) begin
          o_device_addr <= i_rom_data[DEV_HI:DEV_LO];
          o_data_addr   <= i_rom_data[REG_HI:REG_LO];
          o_write_data  <= i_rom_data[DAT_HI:DAT_LO];
        end
        S_ISSUE: begin
          if (i_done_flag) begin
            idx   <= idx + ROM_AW'(1);
            retry <= '0;
            wrap  <= &idx;
          end else if (tmr_exp) begin
            if (!last_try) begin
              retry <= retry + RW'(1);
            end else begin
              o_err     <= 1'b1;
              o_err_idx <= idx;
            end
          end
        end
`ifdef I2C_SEQ_DELAY_EN
        S_DELAY: if (tmr_exp) idx <= idx + ROM_AW'(1);
`endif
        default: ;
      endcase
    end
  end

  assign o_rom_addr = idx;
  assign o_busy     = !(state inside {S_IDLE, S_FINISH, S_ERROR});
  assign o_done     = (state == S_FINISH);

endmodule
